// File: rtl/irq_priority_ctrl_pkg.sv
// rtl/irq_priority_ctrl_pkg.sv - shared FSM state and arbitration mode constants
package irq_priority_ctrl_pkg;

  // Presenter FSM state: IDLE drives req low, PRESENT drives req high
  typedef logic [0:0] state_t;
  localparam state_t IDLE    = 1'b0;
  localparam state_t PRESENT = 1'b1;

  // Arbitration mode encodings for the mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/irq_priority_ctrl_prio_find.sv
// rtl/irq_priority_ctrl_prio_find.sv - combinational highest-set-bit finder
module prio_find #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Ascending scan so the highest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// rtl/irq_priority_ctrl.sv - pending-latch interrupt arbiter with fixed or round-robin grant
module irq_priority_ctrl
  import irq_priority_ctrl_pkg::*;
#(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] irq_in,
  input  logic [N-1:0] mask,
  input  logic         mode,
  input  logic         ack,
  output logic         req,
  output logic [W-1:0] id,
  output logic [N-1:0] pending
);

  // N always fits in W+1 bits, so the un-rotate sum can be wrapped with one subtract
  localparam logic [W:0]   N_V = (W+1)'(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [W-1:0]   last;
  logic [N-1:0]   cand;
  logic [N-1:0]   rot;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   find_vec;
  logic [W-1:0]   find_idx;
  logic           find_valid;
  logic [W-1:0]   offset;
  logic [W:0]     sum;
  logic [W-1:0]   sel;
  logic [N-1:0]   clr;

  // Eligible requests, and cand rotated so that line (last-1) mod N lands on the top bit
  always_comb begin
    cand = pending & mask;
    dbl  = {cand, cand};
    rot  = dbl[last +: N];
  end

  // Fixed mode searches cand directly; round-robin searches the rotated copy
  always_comb begin
    if (mode == MODE_RR) begin
      find_vec = rot;
      offset   = last;
    end else begin
      find_vec = cand;
      offset   = '0;
    end
  end

  prio_find #(
    .N (N),
    .W (W)
  ) u_prio_find (
    .vec   (find_vec),
    .idx   (find_idx),
    .valid (find_valid)
  );

  // Map the rotated index back to a line number, wrapping modulo N
  always_comb begin
    sum = {1'b0, find_idx} + {1'b0, offset};
    if (sum >= N_V) begin
      sel = W'(sum - N_V);
    end else begin
      sel = sum[W-1:0];
    end
  end

  // One-hot clear of the presented line when the consumer accepts it
  always_comb begin
    if (state == PRESENT && ack) begin
      clr = ONE << id;
    end else begin
      clr = '0;
    end
  end

  // Pending latch: new requests OR in after the clear, so a same-cycle request survives its ack
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | irq_in;
    end
  end

  // Presenter FSM: latch a selection from IDLE, hold it until ack, then force an idle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id    <= '0;
      last  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (find_valid) begin
            state <= PRESENT;
            id    <= sel;
          end
        end
        PRESENT: begin
          if (ack) begin
            state <= IDLE;
            last  <= id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req = (state == PRESENT);

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb/tb_irq_priority_ctrl.sv - directed self-checking bench for irq_priority_ctrl at N=16, 2, 32
module tb_irq_priority_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic [15:0] irq_a, mask_a, pend_a;
  logic        mode_a, ack_a, req_a;
  logic [3:0]  id_a;

  logic [1:0]  irq_b, mask_b, pend_b;
  logic        mode_b, ack_b, req_b;
  logic [0:0]  id_b;

  logic [31:0] irq_c, mask_c, pend_c;
  logic        mode_c, ack_c, req_c;
  logic [4:0]  id_c;

  int total = 0;
  int bad   = 0;

  irq_priority_ctrl #(.N(16)) dut_a (
    .clk(clk), .rst(rst), .irq_in(irq_a), .mask(mask_a), .mode(mode_a),
    .ack(ack_a), .req(req_a), .id(id_a), .pending(pend_a)
  );

  irq_priority_ctrl #(.N(2)) dut_b (
    .clk(clk), .rst(rst), .irq_in(irq_b), .mask(mask_b), .mode(mode_b),
    .ack(ack_b), .req(req_b), .id(id_b), .pending(pend_b)
  );

  irq_priority_ctrl #(.N(32)) dut_c (
    .clk(clk), .rst(rst), .irq_in(irq_c), .mask(mask_c), .mode(mode_c),
    .ack(ack_c), .req(req_c), .id(id_c), .pending(pend_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_a = 16'h0101; ack_a = 1'b1;
    step(); step();
    rst = 1'b0; irq_a = '0; ack_a = 1'b0;
    total++; if (req_a !== 1'b0) begin bad++; $display("FAIL reset_req got=%0d want=0", req_a); end
    total++; if (id_a !== 4'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", id_a); end
    total++; if (pend_a !== 16'h0000) begin bad++; $display("FAIL reset_pending got=%h want=0000", pend_a); end
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    total++; if (req_a !== 1'b0) begin bad++; $display("FAIL idle_ack_req got=%0d want=0", req_a); end
  endtask

  task automatic test_fixed();
    do_reset();
    mode_a = 1'b0; mask_a = 16'hFFFF; irq_a = 16'h0820;
    step();
    irq_a = '0;
    total++; if (req_a !== 1'b0) begin bad++; $display("FAIL fixed_lat1_req got=%0d want=0", req_a); end
    total++; if (pend_a !== 16'h0820) begin bad++; $display("FAIL fixed_pending got=%h want=0820", pend_a); end
    step();
    total++; if (req_a !== 1'b1 || id_a !== 4'd11) begin bad++; $display("FAIL fixed_first got req=%0d id=%0d want req=1 id=11", req_a, id_a); end
    ack_a = 1'b1; step(); ack_a = 1'b0;
    total++; if (req_a !== 1'b0 || pend_a !== 16'h0020) begin bad++; $display("FAIL fixed_gap got req=%0d pend=%h want req=0 pend=0020", req_a, pend_a); end
    total++; if (id_a !== 4'd11) begin bad++; $display("FAIL fixed_id_idle got=%0d want=11", id_a); end
    step();
    total++; if (req_a !== 1'b1 || id_a !== 4'd5) begin bad++; $display("FAIL fixed_second got req=%0d id=%0d want req=1 id=5", req_a, id_a); end
    ack_a = 1'b1; step(); ack_a = 1'b0;
    total++; if (req_a !== 1'b0 || pend_a !== 16'h0000) begin bad++; $display("FAIL fixed_drain got req=%0d pend=%h want req=0 pend=0000", req_a, pend_a); end
  endtask

  task automatic test_round_robin();
    int exp_id[4] = '{15, 0, 15, 0};
    do_reset();
    mode_a = 1'b1; irq_a = 16'h8001;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      total++; if (req_a !== 1'b1 || id_a !== 4'(exp_id[k])) begin bad++; $display("FAIL rr_grant%0d got req=%0d id=%0d want req=1 id=%0d", k, req_a, id_a, exp_id[k]); end
      ack_a = 1'b1; step(); ack_a = 1'b0;
      total++; if (req_a !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got req=%0d want=0", k, req_a); end
      step();
    end
    irq_a = '0; mode_a = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    irq_a = 16'h0008; step(); irq_a = '0; step();
    irq_a = 16'h1000; step(); irq_a = '0;
    total++; if (req_a !== 1'b1 || id_a !== 4'd3 || pend_a !== 16'h1008) begin bad++; $display("FAIL hold_a got req=%0d id=%0d pend=%h want req=1 id=3 pend=1008", req_a, id_a, pend_a); end
    step();
    total++; if (req_a !== 1'b1 || id_a !== 4'd3) begin bad++; $display("FAIL hold_b got req=%0d id=%0d want req=1 id=3", req_a, id_a); end
    ack_a = 1'b1; step(); ack_a = 1'b0;
    step();
    total++; if (req_a !== 1'b1 || id_a !== 4'd12) begin bad++; $display("FAIL hold_next got req=%0d id=%0d want req=1 id=12", req_a, id_a); end
    ack_a = 1'b1; step(); ack_a = 1'b0;
  endtask

  task automatic test_mask();
    do_reset();
    mask_a = 16'hFF7F; irq_a = 16'h0080; step(); irq_a = '0;
    step(); step();
    total++; if (req_a !== 1'b0 || pend_a !== 16'h0080) begin bad++; $display("FAIL mask_hold got req=%0d pend=%h want req=0 pend=0080", req_a, pend_a); end
    mask_a = 16'hFFFF;
    step(); step();
    total++; if (req_a !== 1'b1 || id_a !== 4'd7) begin bad++; $display("FAIL mask_grant got req=%0d id=%0d want req=1 id=7", req_a, id_a); end
    ack_a = 1'b1; step(); ack_a = 1'b0;
  endtask

  task automatic test_collision_reset();
    do_reset();
    irq_a = 16'h0010; step(); irq_a = '0; step();
    ack_a = 1'b1; irq_a = 16'h0010; step(); ack_a = 1'b0; irq_a = '0;
    total++; if (req_a !== 1'b0 || pend_a !== 16'h0010) begin bad++; $display("FAIL coll_pend got req=%0d pend=%h want req=0 pend=0010", req_a, pend_a); end
    step();
    total++; if (req_a !== 1'b1 || id_a !== 4'd4) begin bad++; $display("FAIL coll_regrant got req=%0d id=%0d want req=1 id=4", req_a, id_a); end
    irq_a = 16'h0101; step(); irq_a = '0;
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (req_a !== 1'b0 || pend_a !== 16'h0000 || id_a !== 4'd0) begin bad++; $display("FAIL rst_present got req=%0d pend=%h id=%0d want req=0 pend=0000 id=0", req_a, pend_a, id_a); end
  endtask

  task automatic test_sweep_n2();
    int exp_id[4] = '{1, 0, 1, 0};
    do_reset();
    irq_b = 2'b11; step(); irq_b = '0; step();
    total++; if (req_b !== 1'b1 || id_b !== 1'b1) begin bad++; $display("FAIL n2_fixed_a got req=%0d id=%0d want req=1 id=1", req_b, id_b); end
    ack_b = 1'b1; step(); ack_b = 1'b0; step();
    total++; if (req_b !== 1'b1 || id_b !== 1'b0) begin bad++; $display("FAIL n2_fixed_b got req=%0d id=%0d want req=1 id=0", req_b, id_b); end
    ack_b = 1'b1; step(); ack_b = 1'b0;
    total++; if (pend_b !== 2'b00) begin bad++; $display("FAIL n2_drain got=%b want=00", pend_b); end
    do_reset();
    mode_b = 1'b1; irq_b = 2'b11; step(); step();
    for (int k = 0; k < 4; k++) begin
      total++; if (req_b !== 1'b1 || id_b !== 1'(exp_id[k])) begin bad++; $display("FAIL n2_rr%0d got req=%0d id=%0d want req=1 id=%0d", k, req_b, id_b, exp_id[k]); end
      ack_b = 1'b1; step(); ack_b = 1'b0; step();
    end
    irq_b = '0; mode_b = 1'b0;
  endtask

  task automatic test_sweep_n32();
    int exp_id[4] = '{31, 0, 31, 0};
    do_reset();
    irq_c = 32'h8000_0001; step(); irq_c = '0; step();
    total++; if (req_c !== 1'b1 || id_c !== 5'd31) begin bad++; $display("FAIL n32_fixed_a got req=%0d id=%0d want req=1 id=31", req_c, id_c); end
    ack_c = 1'b1; step(); ack_c = 1'b0; step();
    total++; if (req_c !== 1'b1 || id_c !== 5'd0) begin bad++; $display("FAIL n32_fixed_b got req=%0d id=%0d want req=1 id=0", req_c, id_c); end
    ack_c = 1'b1; step(); ack_c = 1'b0;
    total++; if (pend_c !== 32'h0) begin bad++; $display("FAIL n32_drain got=%h want=00000000", pend_c); end
    do_reset();
    mode_c = 1'b1; irq_c = 32'h8000_0001; step(); step();
    for (int k = 0; k < 4; k++) begin
      total++; if (req_c !== 1'b1 || id_c !== 5'(exp_id[k])) begin bad++; $display("FAIL n32_rr%0d got req=%0d id=%0d want req=1 id=%0d", k, req_c, id_c, exp_id[k]); end
      ack_c = 1'b1; step(); ack_c = 1'b0;
      total++; if (req_c !== 1'b0) begin bad++; $display("FAIL n32_rr_gap%0d got req=%0d want=0", k, req_c); end
      step();
    end
    irq_c = '0; mode_c = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    irq_a = '0; mask_a = 16'hFFFF; mode_a = 1'b0; ack_a = 1'b0;
    irq_b = '0; mask_b = 2'b11;    mode_b = 1'b0; ack_b = 1'b0;
    irq_c = '0; mask_c = '1;       mode_c = 1'b0; ack_c = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_hold();
    test_mask();
    test_collision_reset();
    test_sweep_n2();
    test_sweep_n32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_priority_ctrl.md
IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: number of request lines; legal range 2..32.
REQ-002 SHALL have parameter W, default $clog2(N): id width; not overridden by instantiators.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port irq_in, input, N: request lines; bit i high on an edge sets pending[i].
REQ-006 SHALL have port mask, input, N: enables; 1 = line i eligible for grant.
REQ-007 SHALL have port mode, input, 1: arbitration mode; 0 = fixed priority, 1 = round-robin.
REQ-008 SHALL have port ack, input, 1: consumer accepts the presented id.
REQ-009 SHALL have port req, output, 1: a granted id is presented.
REQ-010 SHALL have port id, output, W: index of the granted line; registered.
REQ-011 SHALL have port pending, output, N: registered pending vector.

Function
REQ-012 SHALL compute cand = pending & mask combinationally.
REQ-013 Fixed mode SHALL select the highest set index of cand.
REQ-014 Round-robin mode SHALL give top priority to index (last-1) mod N, then descend with wrap; last = most recently acked id.
REQ-015 SHALL implement a 2-state FSM: IDLE (req=0) and PRESENT (req=1).
REQ-016 IDLE -> PRESENT when cand != 0; id latched from the REQ-013/014 selection on the same edge. Latency: irq_in edge to req is 2 edges (pending, then grant).
REQ-017 In PRESENT, id SHALL stay stable until ack, even if a higher-priority line arrives or mask/mode change.
REQ-018 PRESENT with ack=1 SHALL on that edge: clear pending[id], set last=id, go to IDLE.
REQ-019 Consecutive grants SHALL be separated by at least one req=0 cycle.
REQ-020 ack while IDLE SHALL be ignored; no state change.
REQ-021 If irq_in[id]=1 in the ack cycle, set SHALL win: pending[id] stays 1.
REQ-022 Pending bits of masked lines SHALL be retained and become eligible when unmasked.
REQ-023 A mode change SHALL take effect at the next IDLE selection; last is preserved.
REQ-024 id SHALL keep its previous value while IDLE.

Reset
REQ-025 With rst=1 on an edge: pending=0, req=0, id=0, last=0, state=IDLE; rst overrides irq_in and ack on that edge.
REQ-026 Reset mid-PRESENT SHALL drop req on the same edge and discard all pending requests.
REQ-027 With last=0 after reset, the first round-robin selection SHALL match fixed priority (index N-1 highest).

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE, PRESENT) and the mode constants MODE_FIXED=0, MODE_RR=1.
REQ-029 SHALL instantiate one sub-module, prio_find (parameter N): combinational highest-set-bit finder returning a W-bit index and a valid flag.
REQ-030 Round-robin SHALL be realised by rotating cand by last, applying prio_find, and un-rotating the index mod N.

Verification
REQ-031 Fixed: N=16, mask=FFFF, mode=0, pulse irq_in=0x0820 for 1 cycle -> req after 2 edges with id=11; ack -> id=5 after one idle cycle; ack -> req=0, pending=0.
REQ-032 Round-robin: mode=1, irq_in held at 0x8001 -> grants 15, 0, 15, 0 with one idle cycle between grants.
REQ-033 Hold: while presenting id=3, assert irq_in[12] -> id stays 3 until ack, then id=12.
REQ-034 Mask: pulse irq_in[7] with mask[7]=0 -> req=0, pending=0x0080; set mask[7]=1 -> req with id=7 two edges later.
REQ-035 Collision/reset: irq_in[4]=1 in ack cycle of id=4 -> pending[4] stays 1 and id=4 is re-granted; rst during PRESENT -> req=0, pending=0 on the next edge.
REQ-036 Parameter sweep: N=2 and N=32 rerun REQ-031/032 with indices scaled (e.g. N=32: irq_in bits 31 and 0 -> id=31 then 0).
